// File: rtl/axon_spike_scheduler.sv
// Double-buffered axon spike collector that, on each tick, walks the frozen
// spike mask lowest index first and emits one active axon per cycle.
module axon_spike_scheduler #(
   parameter  int NUM_AXONS = 256,
   localparam int AW        = (NUM_AXONS > 1) ? $clog2(NUM_AXONS) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          spike_in_valid,
   input  logic [AW-1:0] spike_in_axon,
   input  logic          tick,
   output logic [AW-1:0] axon_number,
   output logic          axon_valid,
   output logic          scan_busy,
   output logic          scan_done,
   output logic          tick_error
);

   typedef enum logic {
      IDLE = 1'b0,
      SCAN = 1'b1
   } state_e;

   state_e                      state_q, state_d;
   logic                        wr_sel_q, wr_sel_d;
   logic [1:0][NUM_AXONS-1:0]   buf_q, buf_d;
   logic [AW-1:0]               axon_number_q, axon_number_d;
   logic                        axon_valid_q, axon_valid_d;
   logic                        scan_done_q, scan_done_d;
   logic                        tick_error_q, tick_error_d;

   logic [NUM_AXONS-1:0]        scan_mask;
   logic                        mask_any;
   logic [AW-1:0]               first_idx;
   logic                        wr_in_range;

   // Out-of-range indices can only occur when NUM_AXONS is not a power of two.
   if ((1 << AW) == NUM_AXONS) begin : gen_pow2
      assign wr_in_range = 1'b1;
   end else begin : gen_non_pow2
      assign wr_in_range = ({1'b0, spike_in_axon} < (AW+1)'(NUM_AXONS));
   end

   assign scan_mask = buf_q[~wr_sel_q];
   assign mask_any  = |scan_mask;

   always_comb begin
      first_idx = '0;
      for (int i = NUM_AXONS - 1; i >= 0; i--) begin
         if (scan_mask[i]) first_idx = AW'(i);
      end
   end

   always_comb begin
      // NOTE: every signal gets a default before any branch so no latch can be inferred.
      state_d       = state_q;
      wr_sel_d      = wr_sel_q;
      buf_d         = buf_q;
      axon_number_d = axon_number_q;
      axon_valid_d  = 1'b0;
      scan_done_d   = 1'b0;
      tick_error_d  = 1'b0;

      // Applied before the swap so a same-cycle spike joins the tick being scanned.
      if (spike_in_valid && wr_in_range) buf_d[wr_sel_q][spike_in_axon] = 1'b1;

      case (state_q)
         IDLE: begin
            if (tick) begin
               wr_sel_d = ~wr_sel_q;
               state_d  = SCAN;
            end
         end
         SCAN: begin
            if (tick) tick_error_d = 1'b1;
            if (mask_any) begin
               axon_number_d                 = first_idx;
               axon_valid_d                  = 1'b1;
               buf_d[~wr_sel_q][first_idx]   = 1'b0;
            end else begin
               scan_done_d = 1'b1;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         // NOTE: the spike buffers are reset too, since a reset must discard pending spikes.
         state_q       <= IDLE;
         wr_sel_q      <= 1'b0;
         buf_q         <= '0;
         axon_number_q <= '0;
         axon_valid_q  <= 1'b0;
         scan_done_q   <= 1'b0;
         tick_error_q  <= 1'b0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments only.
         state_q       <= state_d;
         wr_sel_q      <= wr_sel_d;
         buf_q         <= buf_d;
         axon_number_q <= axon_number_d;
         axon_valid_q  <= axon_valid_d;
         scan_done_q   <= scan_done_d;
         tick_error_q  <= tick_error_d;
      end
   end

   assign axon_number = axon_number_q;
   assign axon_valid  = axon_valid_q;
   assign scan_busy   = (state_q == SCAN);
   assign scan_done   = scan_done_q;
   assign tick_error  = tick_error_q;

endmodule

// File: tb/tb_axon_spike_scheduler.sv
// Directed bench for axon_spike_scheduler: spike collection, ordered scan,
// dropped ticks, same-cycle writes and mid-scan reset.
module tb_axon_spike_scheduler;

   localparam int NUM_AXONS = 256;
   localparam int AW        = 8;

   logic          clk;
   logic          rst;
   logic          spike_in_valid;
   logic [AW-1:0] spike_in_axon;
   logic          tick;
   logic [AW-1:0] axon_number;
   logic          axon_valid;
   logic          scan_busy;
   logic          scan_done;
   logic          tick_error;

   int n_checks = 0;
   int n_fail   = 0;
   int exp_q[$];

   axon_spike_scheduler #(.NUM_AXONS(NUM_AXONS)) dut (
      .clk            (clk),
      .rst            (rst),
      .spike_in_valid (spike_in_valid),
      .spike_in_axon  (spike_in_axon),
      .tick           (tick),
      .axon_number    (axon_number),
      .axon_valid     (axon_valid),
      .scan_busy      (scan_busy),
      .scan_done      (scan_done),
      .tick_error     (tick_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance past the next rising edge; outputs are settled 1 ns later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_spike(input int axon);
      spike_in_valid = 1'b1;
      spike_in_axon  = AW'(axon);
      step();
      spike_in_valid = 1'b0;
   endtask

   task automatic do_tick();
      tick = 1'b1;
      step();
      tick = 1'b0;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, ".valid"}, int'(axon_valid), 0);
      check({tag, ".busy"},  int'(scan_busy),  0);
      check({tag, ".done"},  int'(scan_done),  0);
      check({tag, ".err"},   int'(tick_error), 0);
   endtask

   // Called just after the accepted tick edge; returns in the scan_done cycle.
   task automatic expect_scan(input string tag);
      check({tag, ".busy0"}, int'(scan_busy), 1);
      foreach (exp_q[i]) begin
         step();
         check({tag, ".valid"}, int'(axon_valid),  1);
         check({tag, ".num"},   int'(axon_number), exp_q[i]);
         check({tag, ".busy"},  int'(scan_busy),   1);
         check({tag, ".done"},  int'(scan_done),   0);
      end
      step();
      check({tag, ".end_valid"}, int'(axon_valid), 0);
      check({tag, ".end_done"},  int'(scan_done),  1);
      check({tag, ".end_busy"},  int'(scan_busy),  0);
      check({tag, ".end_err"},   int'(tick_error), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst            = 1'b1;
      spike_in_valid = 1'b0;
      spike_in_axon  = '0;
      tick           = 1'b0;

      // 1: reset, then an empty tick
      step();
      step();
      check_idle_outputs("rst_held");
      check("rst_held.num", int'(axon_number), 0);
      rst = 1'b0;
      step();
      check_idle_outputs("rst_rel");
      check("rst_rel.num", int'(axon_number), 0);
      do_tick();
      exp_q = {};
      expect_scan("empty");
      step();
      check("empty.done_clear", int'(scan_done), 0);

      // 2: unordered writes with a duplicate
      write_spike(200);
      write_spike(3);
      write_spike(77);
      write_spike(3);
      do_tick();
      exp_q = {3, 77, 200};
      expect_scan("dup");
      step();
      check("dup.hold_num", int'(axon_number), 200);
      check("dup.hold_valid", int'(axon_valid), 0);

      // 3: every axon active
      for (int i = 0; i < NUM_AXONS; i++) write_spike(i);
      do_tick();
      exp_q = {};
      for (int i = 0; i < NUM_AXONS; i++) exp_q.push_back(i);
      expect_scan("all");
      step();
      check("all.hold_num", int'(axon_number), 255);

      // 4: tick during scan is dropped, concurrent write deferred
      write_spike(10);
      write_spike(20);
      do_tick();
      check("busy_tick.busy0", int'(scan_busy), 1);
      spike_in_valid = 1'b1;
      spike_in_axon  = AW'(5);
      tick           = 1'b1;
      step();
      spike_in_valid = 1'b0;
      tick           = 1'b0;
      check("busy_tick.err",    int'(tick_error),  1);
      check("busy_tick.num10",  int'(axon_number), 10);
      check("busy_tick.valid1", int'(axon_valid),  1);
      step();
      check("busy_tick.err_clr", int'(tick_error), 0);
      check("busy_tick.num20",   int'(axon_number), 20);
      check("busy_tick.valid2",  int'(axon_valid),  1);
      step();
      check("busy_tick.done",  int'(scan_done),  1);
      check("busy_tick.valid", int'(axon_valid), 0);
      step();
      do_tick();
      exp_q = {5};
      expect_scan("deferred5");
      step();

      // 5: same-cycle write joins the scan; one cycle later is deferred
      spike_in_valid = 1'b1;
      spike_in_axon  = AW'(42);
      tick           = 1'b1;
      step();
      tick           = 1'b0;
      spike_in_axon  = AW'(43);
      check("same.busy", int'(scan_busy), 1);
      step();
      spike_in_valid = 1'b0;
      check("same.valid42", int'(axon_valid),  1);
      check("same.num42",   int'(axon_number), 42);
      step();
      check("same.done", int'(scan_done),  1);
      check("same.busy_clr", int'(scan_busy), 0);
      // Tick in the scan_done cycle must be accepted.
      do_tick();
      check("late.err", int'(tick_error), 0);
      exp_q = {43};
      expect_scan("late43");
      step();

      // 6: reset mid-scan discards everything
      write_spike(1);
      write_spike(2);
      write_spike(3);
      do_tick();
      step();
      check("mid.valid", int'(axon_valid),  1);
      check("mid.num",   int'(axon_number), 1);
      rst = 1'b1;
      step();
      check_idle_outputs("mid_rst");
      check("mid_rst.num", int'(axon_number), 0);
      rst = 1'b0;
      step();
      do_tick();
      exp_q = {};
      expect_scan("post_rst");
      step();
      check("post_rst.done_clr", int'(scan_done), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
